alarm_siren_ctrl: RTL and testbench

Downstream stage of the alarm-detect logic: consumes the combined alarm request and sensor vector and drives the siren. Applies an entry delay, sounds a timed (optionally pulsed) siren and latches the tripping zone. Remains in a tripped state until disarmed. Sits between the alarm detector output and the physical siren/indicator pins.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_timer.sv | 37 +++
 rtl/alarm_siren_ctrl.sv | 158 +++++++++++++++
 tb/tb_alarm_siren_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and widths for the alarm siren controller
package alarm_pkg;

  localparam int STATE_W = 3;
  localparam int SEN_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    SOUND = 3'd3,
    HOLD  = 3'd4
  } state_e;

  function automatic logic is_tripped(input state_e s);
    return (s == DELAY) || (s == SOUND) || (s == HOLD);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - loadable down-counter that holds at zero; clear beats load beats count
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/alarm_siren_ctrl.sv
// rtl/alarm_siren_ctrl.sv - entry delay, timed siren and zone latch after the alarm detector
// Define SIREN_PULSE_EN to build the pulsed siren; otherwise the siren is steady during SOUND.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int DELAY_CYC = 16,
  parameter int SOUND_CYC = 64,
  parameter int PULSE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic               Alarm_IN,
  input  logic [SEN_W-1:0]   SEN,
  output logic               siren,
  output logic               tripped,
  output logic [STATE_W-1:0] state,
  output logic [SEN_W-1:0]   zone_q
);

  localparam int MAX_CYC = (DELAY_CYC > SOUND_CYC) ? DELAY_CYC : SOUND_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e             state_q, state_d;
  logic [SEN_W-1:0]   zone_d;
  logic               siren_q, siren_d;
  logic               tripped_q;

  logic               cnt_clr, cnt_ld, cnt_en, cnt_done;
  logic [CNT_W-1:0]   cnt_ld_val;
  logic               sound_start;

  always_comb begin
    state_d     = state_q;
    zone_d      = zone_q;
    cnt_clr     = 1'b0;
    cnt_ld      = 1'b0;
    cnt_ld_val  = '0;
    cnt_en      = 1'b0;
    sound_start = 1'b0;

    if (!EN) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          zone_d  = '0;
        end
        ARMED, HOLD: begin
          if (Alarm_IN) begin
            state_d    = DELAY;
            zone_d     = SEN;
            cnt_ld     = 1'b1;
            cnt_ld_val = CNT_W'(DELAY_CYC - 1);
          end
        end
        DELAY: begin
          if (cnt_done) begin
            state_d     = SOUND;
            cnt_ld      = 1'b1;
            cnt_ld_val  = CNT_W'(SOUND_CYC - 1);
            sound_start = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        SOUND: begin
          if (cnt_done) begin
            state_d = HOLD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  alarm_timer #(.W(CNT_W)) u_main_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

`ifdef SIREN_PULSE_EN
  localparam int PCNT_W = $clog2(PULSE_CYC + 1);

  logic phase_q, phase_d;
  logic pulse_ld, pulse_en, pulse_done;

  // Phase only advances while staying in SOUND; entry always starts high with a full half-period.
  always_comb begin
    phase_d  = phase_q;
    pulse_ld = 1'b0;
    pulse_en = 1'b0;
    if (sound_start) begin
      phase_d  = 1'b1;
      pulse_ld = 1'b1;
    end else if (EN && (state_q == SOUND) && (state_d == SOUND)) begin
      if (pulse_done) begin
        phase_d  = ~phase_q;
        pulse_ld = 1'b1;
      end else begin
        pulse_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  alarm_timer #(.W(PCNT_W)) u_pulse_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (pulse_ld),
    .load_val (PCNT_W'(PULSE_CYC - 1)),
    .en       (pulse_en),
    .done     (pulse_done)
  );

  assign siren_d = (state_d == SOUND) && phase_d;
`else
  assign siren_d = (state_d == SOUND);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      zone_q    <= '0;
      siren_q   <= 1'b0;
      tripped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      zone_q    <= zone_d;
      siren_q   <= siren_d;
      tripped_q <= is_tripped(state_d);
    end
  end

  assign siren   = siren_q;
  assign tripped = tripped_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// tb/tb_alarm_siren_ctrl.sv - directed self-checking bench for alarm_siren_ctrl at default parameters
module tb_alarm_siren_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN;
  logic       Alarm_IN;
  logic [3:0] SEN;
  logic       siren;
  logic       tripped;
  logic [2:0] state;
  logic [3:0] zone_q;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_siren_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .Alarm_IN (Alarm_IN),
    .SEN      (SEN),
    .siren    (siren),
    .tripped  (tripped),
    .state    (state),
    .zone_q   (zone_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic sr,
                            input logic tr, input logic [3:0] zn);
    check({tag, ".state"},   32'(state),   32'(st));
    check({tag, ".siren"},   32'(siren),   32'(sr));
    check({tag, ".tripped"}, 32'(tripped), 32'(tr));
    check({tag, ".zone"},    32'(zone_q),  32'(zn));
  endtask

  function automatic logic exp_siren(input int i);
`ifdef SIREN_PULSE_EN
    return ((i / 4) % 2) == 0;
`else
    return (i >= 0);
`endif
  endfunction

  initial begin
    rst = 1'b1; EN = 1'b0; Alarm_IN = 1'b0; SEN = 4'b0000;
    #1;
    step(); step();
    check_outs("reset", 3'd0, 1'b0, 1'b0, 4'h0);

    rst = 1'b0; EN = 1'b1;
    step();
    check_outs("arm", 3'd1, 1'b0, 1'b0, 4'h0);

    Alarm_IN = 1'b1; SEN = 4'b0100;
    step();
    check_outs("trigger", 3'd2, 1'b0, 1'b1, 4'b0100);
    Alarm_IN = 1'b0; SEN = 4'b0000;

    for (int i = 1; i < 16; i++) begin
      step();
      check("delay1.state", 32'(state), 32'd2);
    end
    step();
    for (int i = 0; i < 64; i++) begin
      check("sound1.state", 32'(state), 32'd3);
      check("sound1.siren", 32'(siren), 32'(exp_siren(i)));
      step();
    end
    check_outs("hold", 3'd4, 1'b0, 1'b1, 4'b0100);
    step();
    check("hold.stay", 32'(state), 32'd4);

    Alarm_IN = 1'b1; SEN = 4'b1000;
    step();
    check_outs("retrigger", 3'd2, 1'b0, 1'b1, 4'b1000);
    Alarm_IN = 1'b0; SEN = 4'b0000;
    for (int i = 1; i < 16; i++) begin
      step();
      check("delay2.state", 32'(state), 32'd2);
    end
    step();
    check("sound2.entry", 32'(state), 32'd3);
    for (int i = 0; i < 5; i++) step();
    check("sound2.mid", 32'(state), 32'd3);
    EN = 1'b0;
    step();
    check_outs("disarm", 3'd0, 1'b0, 1'b0, 4'b1000);

    EN = 1'b1;
    step();
    check("rearm.zone_clr", 32'(zone_q), 32'd0);
    Alarm_IN = 1'b1; SEN = 4'b0001;
    step();
    check("trig3.state", 32'(state), 32'd2);
    for (int i = 0; i < 16; i++) step();
    check_outs("sound3", 3'd3, 1'b1, 1'b1, 4'b0001);
    rst = 1'b1;
    step();
    check_outs("rst_in_sound", 3'd0, 1'b0, 1'b0, 4'h0);

    rst = 1'b0;
    step();
    check("idle_en_alarm", 32'(state), 32'd1);
    step();
    check("armed_then_trig", 32'(state), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
